// File: rtl/pipeline_pkg.sv
// Shared widths and FSM encoding for the pipeline memory arbiter.
// Imported by the arbiter and by anything that snoops its state.
package pipeline_pkg;

   localparam int ADDR_W = 10;
   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arb_state_t;

   typedef enum logic {
      PORT_IF = 1'b0,
      PORT_DM = 1'b1
   } port_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (IF/DM) arbiter onto one single-port memory.
// DM has priority; a streak counter keeps IF from starving.
module mem_arbiter
   import pipeline_pkg::*;
#(
   parameter int MEM_LAT = 1,
   parameter int STREAK  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_valid,
   output logic              if_stall,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_valid,
   output logic              dm_stall,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam logic [3:0] STREAK_C = 4'(STREAK);
   localparam logic [2:0] LAT_LAST = 3'(MEM_LAT - 1);

   arb_state_t state;
   arb_state_t state_nxt;
   port_t      grant;
   logic       lat_we;
   logic [3:0] streak;
   logic [2:0] lat_cnt;
   logic       any_req;
   logic       if_wins;

   assign any_req = if_req | dm_req;
   assign if_wins = if_req & (~dm_req | (streak == STREAK_C));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      if_valid  = 1'b0;
      dm_valid  = 1'b0;
      busy      = (state != IDLE);
      unique case (state)
         IDLE: begin
            if (any_req) state_nxt = ISSUE;
         end
         ISSUE: begin
            mem_en    = 1'b1;
            mem_we    = lat_we;
            state_nxt = WAIT;
         end
         WAIT: begin
            if (lat_cnt == LAT_LAST) state_nxt = RESP;
         end
         RESP: begin
            if_valid  = (grant == PORT_IF);
            dm_valid  = (grant == PORT_DM);
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Inputs are only looked at in IDLE; the latched copy drives the bus.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant     <= PORT_IF;
         lat_we    <= 1'b0;
         streak    <= 4'd0;
         lat_cnt   <= 3'd0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_rdata  <= '0;
         dm_rdata  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (any_req) begin
                  if (if_wins) begin
                     grant    <= PORT_IF;
                     lat_we   <= 1'b0;
                     mem_addr <= if_addr;
                     streak   <= 4'd0;
                  end else begin
                     grant     <= PORT_DM;
                     lat_we    <= dm_we;
                     mem_addr  <= dm_addr;
                     mem_wdata <= dm_wdata;
                     if (if_req && streak != STREAK_C)
                        streak <= streak + 4'd1;
                  end
               end
            end
            ISSUE: begin
               lat_cnt <= 3'd0;
            end
            WAIT: begin
               lat_cnt <= lat_cnt + 3'd1;
               if (lat_cnt == LAT_LAST && !lat_we) begin
                  if (grant == PORT_IF) if_rdata <= mem_rdata;
                  else                  dm_rdata <= mem_rdata;
               end
            end
            default: ;
         endcase
      end
   end

   assign if_stall = if_req & ~if_valid;
   assign dm_stall = dm_req & ~dm_valid;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter at MEM_LAT=1 and MEM_LAT=3,
// each DUT backed by a latency-accurate behavioural memory.
module tb_mem_arbiter;

   localparam logic [31:0] BAD = 32'hBAD0BAD0;

   logic        clk;
   logic        rst;
   int          pass_cnt;
   int          total_cnt;

   logic        if_req, dm_req, dm_we;
   logic [9:0]  if_addr, dm_addr, mem_addr;
   logic [31:0] dm_wdata, if_rdata, dm_rdata, mem_wdata, mem_rdata;
   logic        if_valid, dm_valid, if_stall, dm_stall;
   logic        mem_en, mem_we, busy;

   logic        b_if_req, b_dm_req, b_dm_we;
   logic [9:0]  b_if_addr, b_dm_addr, b_mem_addr;
   logic [31:0] b_dm_wdata, b_if_rdata, b_dm_rdata;
   logic [31:0] b_mem_wdata, b_mem_rdata;
   logic        b_if_valid, b_dm_valid, b_if_stall, b_dm_stall;
   logic        b_mem_en, b_mem_we, b_busy;

   mem_arbiter #(.MEM_LAT(1), .STREAK(4)) u1 (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr),
      .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
      .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
      .dm_valid(dm_valid), .dm_stall(dm_stall),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
   );

   mem_arbiter #(.MEM_LAT(3), .STREAK(4)) u3 (
      .clk(clk), .rst(rst),
      .if_req(b_if_req), .if_addr(b_if_addr),
      .if_rdata(b_if_rdata), .if_valid(b_if_valid),
      .if_stall(b_if_stall),
      .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr),
      .dm_wdata(b_dm_wdata), .dm_rdata(b_dm_rdata),
      .dm_valid(b_dm_valid), .dm_stall(b_dm_stall),
      .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
      .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] pattern(input logic [9:0] a);
      if (a == 10'h004) return 32'h20080005;
      if (a == 10'h3FF) return 32'hCAFEF00D;
      return {22'h0, a} ^ 32'h12340000;
   endfunction

   // Read data appears only in the cycle MEM_LAT after mem_en.
   logic [31:0] m1_store [0:1023];
   logic        m1_wr    [0:1023];
   logic        m1_v;
   logic [31:0] m1_d;
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 1024; i++) m1_wr[i] <= 1'b0;
      end else if (mem_en && mem_we) begin
         m1_store[mem_addr] <= mem_wdata;
         m1_wr[mem_addr]    <= 1'b1;
      end
      m1_v <= mem_en & ~mem_we;
      m1_d <= m1_wr[mem_addr] ? m1_store[mem_addr] : pattern(mem_addr);
   end
   assign mem_rdata = m1_v ? m1_d : BAD;

   logic [2:0]  m3_v;
   logic [31:0] m3_d [3];
   always @(posedge clk) begin
      m3_v    <= {m3_v[1:0], b_mem_en & ~b_mem_we};
      m3_d[0] <= pattern(b_mem_addr);
      m3_d[1] <= m3_d[0];
      m3_d[2] <= m3_d[1];
   end
   assign b_mem_rdata = m3_v[2] ? m3_d[2] : BAD;

   task automatic zero_inputs();
      if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0;
      dm_addr = '0; dm_wdata = '0;
      b_if_req = 0; b_if_addr = '0; b_dm_req = 0; b_dm_we = 0;
      b_dm_addr = '0; b_dm_wdata = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      zero_inputs();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      zero_inputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      total_cnt++;
      if ({busy, mem_en, mem_we, if_valid, dm_valid} !== 5'b0)
         $display("FAIL reset_ctl: got %b want 00000",
                  {busy, mem_en, mem_we, if_valid, dm_valid});
      else pass_cnt++;
      total_cnt++;
      if ({mem_addr, mem_wdata, if_rdata, dm_rdata} !== '0)
         $display("FAIL reset_data: got %h %h %h %h want 0",
                  mem_addr, mem_wdata, if_rdata, dm_rdata);
      else pass_cnt++;
      total_cnt++;
      if ({u1.streak, u1.lat_cnt} !== 7'd0)
         $display("FAIL reset_cnt: got %h %h want 0",
                  u1.streak, u1.lat_cnt);
      else pass_cnt++;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_if_read();
      do_reset();
      if_addr = 10'h004;
      if_req  = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         total_cnt++;
         if (mem_en !== (c == 1))
            $display("FAIL ifrd_en c%0d: got %b want %b", c, mem_en, c == 1);
         else pass_cnt++;
         total_cnt++;
         if (if_valid !== (c == 3) || dm_valid !== 1'b0)
            $display("FAIL ifrd_valid c%0d: got if=%b dm=%b want if=%b dm=0",
                     c, if_valid, dm_valid, c == 3);
         else pass_cnt++;
         if (c == 0) begin
            total_cnt++;
            if (if_stall !== 1'b1 || busy !== 1'b0)
               $display("FAIL ifrd_c0: got stall=%b busy=%b want 1 0",
                        if_stall, busy);
            else pass_cnt++;
         end
         if (c == 1) begin
            total_cnt++;
            if (mem_addr !== 10'h004 || mem_we !== 1'b0)
               $display("FAIL ifrd_bus: got addr=%h we=%b want 004 0",
                        mem_addr, mem_we);
            else pass_cnt++;
         end
         if (c == 3) begin
            total_cnt++;
            if (if_rdata !== 32'h20080005 || if_stall !== 1'b0)
               $display("FAIL ifrd_data: got %h stall=%b want 20080005 0",
                        if_rdata, if_stall);
            else pass_cnt++;
            if_req = 1'b0;
         end
         tick();
      end
   endtask

   task automatic test_contention();
      do_reset();
      if_addr  = 10'h004;
      dm_addr  = 10'h010;
      dm_we    = 1'b1;
      dm_wdata = 32'hDEADBEEF;
      if_req   = 1'b1;
      dm_req   = 1'b1;
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         total_cnt++;
         if (mem_en !== (c == 1 || c == 5))
            $display("FAIL cont_en c%0d: got %b", c, mem_en);
         else pass_cnt++;
         total_cnt++;
         if (dm_valid !== (c == 3) || if_valid !== (c == 7))
            $display("FAIL cont_valid c%0d: got dm=%b if=%b want dm=%b if=%b",
                     c, dm_valid, if_valid, c == 3, c == 7);
         else pass_cnt++;
         if (c == 1) begin
            total_cnt++;
            if (mem_we !== 1'b1 || mem_addr !== 10'h010 ||
                mem_wdata !== 32'hDEADBEEF)
               $display("FAIL cont_dm_bus: got we=%b addr=%h wd=%h",
                        mem_we, mem_addr, mem_wdata);
            else pass_cnt++;
         end
         if (c == 2) begin
            total_cnt++;
            if (mem_we !== 1'b0 || mem_wdata !== 32'hDEADBEEF)
               $display("FAIL cont_hold: got we=%b wd=%h want 0 deadbeef",
                        mem_we, mem_wdata);
            else pass_cnt++;
         end
         if (c == 3) dm_req = 1'b0;
         if (c == 5) begin
            total_cnt++;
            if (mem_we !== 1'b0 || mem_addr !== 10'h004)
               $display("FAIL cont_if_bus: got we=%b addr=%h want 0 004",
                        mem_we, mem_addr);
            else pass_cnt++;
         end
         if (c == 7) begin
            total_cnt++;
            if (if_rdata !== 32'h20080005)
               $display("FAIL cont_if_data: got %h want 20080005", if_rdata);
            else pass_cnt++;
            if_req = 1'b0;
         end
         tick();
      end
   endtask

   task automatic test_starvation();
      logic [5:0] got;
      int         vcyc [6];
      int         n;
      do_reset();
      if_addr = 10'h004;
      dm_addr = 10'h020;
      if_req  = 1'b1;
      dm_req  = 1'b1;
      n   = 0;
      got = '0;
      for (int c = 0; c < 60 && n < 6; c++) begin
         @(negedge clk);
         if (if_valid || dm_valid) begin
            got[n]  = if_valid;
            vcyc[n] = c;
            if (n == 3) begin
               total_cnt++;
               if (u1.streak !== 4'd4)
                  $display("FAIL starve_sat: got streak=%0d want 4", u1.streak);
               else pass_cnt++;
            end
            if (n == 4) begin
               total_cnt++;
               if (u1.streak !== 4'd0)
                  $display("FAIL starve_clr: got streak=%0d want 0", u1.streak);
               else pass_cnt++;
            end
            n++;
         end
         tick();
      end
      if_req = 1'b0;
      dm_req = 1'b0;
      total_cnt++;
      if (n != 6 || got !== 6'b010000)
         $display("FAIL starve_order: got n=%0d order=%b want 6 010000",
                  n, got);
      else pass_cnt++;
      total_cnt++;
      if (n == 6 && vcyc[0] == 3 && vcyc[5] - vcyc[0] == 20) pass_cnt++;
      else $display("FAIL starve_b2b: got first=%0d span=%0d want 3 20",
                    vcyc[0], vcyc[5] - vcyc[0]);
      repeat (4) tick();
   endtask

   task automatic test_midflight();
      do_reset();
      if_addr = 10'h004;
      if_req  = 1'b1;
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         total_cnt++;
         if (if_valid !== (c == 3) || dm_valid !== (c == 7))
            $display("FAIL mid_valid c%0d: got if=%b dm=%b want if=%b dm=%b",
                     c, if_valid, dm_valid, c == 3, c == 7);
         else pass_cnt++;
         if (c == 1) begin
            dm_req   = 1'b1;
            dm_we    = 1'b1;
            dm_addr  = 10'h0AA;
            dm_wdata = 32'h55555555;
         end
         if (c == 2) begin
            total_cnt++;
            if (mem_we !== 1'b0 || mem_addr !== 10'h004)
               $display("FAIL mid_ignore: got we=%b addr=%h want 0 004",
                        mem_we, mem_addr);
            else pass_cnt++;
            if_req = 1'b0;
         end
         if (c == 3) begin
            total_cnt++;
            if (if_rdata !== 32'h20080005 || dm_stall !== 1'b1)
               $display("FAIL mid_drop: got %h dm_stall=%b want 20080005 1",
                        if_rdata, dm_stall);
            else pass_cnt++;
         end
         if (c == 5) begin
            total_cnt++;
            if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 10'h0AA)
               $display("FAIL mid_dm_issue: got en=%b we=%b addr=%h",
                        mem_en, mem_we, mem_addr);
            else pass_cnt++;
         end
         if (c == 7) dm_req = 1'b0;
         tick();
      end
   endtask

   task automatic test_latency();
      do_reset();
      b_dm_addr = 10'h3FF;
      b_dm_req  = 1'b1;
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         total_cnt++;
         if (b_mem_en !== (c == 1))
            $display("FAIL lat_en c%0d: got %b want %b", c, b_mem_en, c == 1);
         else pass_cnt++;
         total_cnt++;
         if (b_dm_valid !== (c == 5) || b_if_valid !== 1'b0)
            $display("FAIL lat_valid c%0d: got dm=%b if=%b want dm=%b",
                     c, b_dm_valid, b_if_valid, c == 5);
         else pass_cnt++;
         if (c == 0) begin
            total_cnt++;
            if (b_dm_stall !== 1'b1 || b_if_stall !== 1'b0)
               $display("FAIL lat_stall: got dm=%b if=%b want 1 0",
                        b_dm_stall, b_if_stall);
            else pass_cnt++;
         end
         if (c == 1) begin
            total_cnt++;
            if (b_mem_addr !== 10'h3FF || b_mem_we !== 1'b0)
               $display("FAIL lat_bus: got addr=%h we=%b want 3ff 0",
                        b_mem_addr, b_mem_we);
            else pass_cnt++;
         end
         if (c == 5) begin
            total_cnt++;
            if (b_dm_rdata !== 32'hCAFEF00D || b_dm_stall !== 1'b0)
               $display("FAIL lat_data: got %h stall=%b want cafef00d 0",
                        b_dm_rdata, b_dm_stall);
            else pass_cnt++;
            total_cnt++;
            if (b_if_rdata !== 32'h0 || b_mem_wdata !== 32'h0)
               $display("FAIL lat_other: got ifr=%h wd=%h want 0 0",
                        b_if_rdata, b_mem_wdata);
            else pass_cnt++;
            b_dm_req = 1'b0;
         end
         if (c == 6) begin
            total_cnt++;
            if (b_busy !== 1'b0)
               $display("FAIL lat_idle: got busy=%b want 0", b_busy);
            else pass_cnt++;
         end
         tick();
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      dm_addr = 10'h020;
      dm_req  = 1'b1;
      tick();
      tick();
      rst    = 1'b1;
      dm_req = 1'b0;
      for (int c = 2; c < 5; c++) begin
         @(negedge clk);
         total_cnt++;
         if ({busy, mem_en, mem_we, dm_valid, if_valid} !== 5'b0)
            $display("FAIL rstmid_ctl c%0d: got %b want 00000", c,
                     {busy, mem_en, mem_we, dm_valid, if_valid});
         else pass_cnt++;
         total_cnt++;
         if ({mem_addr, mem_wdata, dm_rdata, if_rdata} !== '0)
            $display("FAIL rstmid_data c%0d: got %h %h %h %h want 0", c,
                     mem_addr, mem_wdata, dm_rdata, if_rdata);
         else pass_cnt++;
         tick();
      end
      rst     = 1'b0;
      if_addr = 10'h004;
      if_req  = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         total_cnt++;
         if (mem_en !== (c == 1) || if_valid !== (c == 3) || dm_valid)
            $display("FAIL rstmid_if c%0d: got en=%b if=%b dm=%b",
                     c, mem_en, if_valid, dm_valid);
         else pass_cnt++;
         if (c == 3) if_req = 1'b0;
         tick();
      end
   endtask

   task automatic test_write_ack();
      do_reset();
      dm_addr = 10'h020;
      dm_req  = 1'b1;
      for (int c = 0; c < 13; c++) begin
         if (c == 4) begin
            dm_req   = 1'b1;
            dm_we    = 1'b1;
            dm_addr  = 10'h055;
            dm_wdata = 32'hA5A5A5A5;
         end
         if (c == 8) begin
            dm_req = 1'b1;
            dm_we  = 1'b0;
         end
         @(negedge clk);
         total_cnt++;
         if (dm_valid !== (c == 3 || c == 7 || c == 11))
            $display("FAIL wack_valid c%0d: got %b", c, dm_valid);
         else pass_cnt++;
         if (c == 3 || c == 7) begin
            total_cnt++;
            if (dm_rdata !== 32'h12340020)
               $display("FAIL wack_hold c%0d: got %h want 12340020",
                        c, dm_rdata);
            else pass_cnt++;
         end
         if (c == 11) begin
            total_cnt++;
            if (dm_rdata !== 32'hA5A5A5A5)
               $display("FAIL wack_read: got %h want a5a5a5a5", dm_rdata);
            else pass_cnt++;
         end
         if (c == 3 || c == 7 || c == 11) dm_req = 1'b0;
         tick();
      end
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      rst       = 1'b1;
      zero_inputs();
      test_reset();
      test_if_read();
      test_contention();
      test_starvation();
      test_midflight();
      test_latency();
      test_reset_mid();
      test_write_ack();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 1: cycles from the mem_en cycle to the cycle in which mem_rdata is valid; legal range 1-7.
REQ-002 Parameter STREAK, default 4: consecutive contested DM grants before IF is forced a grant; legal range 1-15.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 if_req  input  1  instruction-fetch read request, held until if_valid.
REQ-006 if_addr  input  10  IF word address, stable while if_req is high.
REQ-007 if_rdata  output  32  fetched instruction, registered.
REQ-008 if_valid  output  1  one-cycle completion pulse for IF.
REQ-009 dm_req  input  1  data-memory request, held until dm_valid.
REQ-010 dm_we  input  1  1 = write, 0 = read, stable while dm_req is high.
REQ-011 dm_addr  input  10  DM word address.
REQ-012 dm_wdata  input  32  DM write data.
REQ-013 dm_rdata  output  32  DM read data, registered.
REQ-014 dm_valid  output  1  one-cycle completion pulse for DM.
REQ-015 mem_en / mem_we  output  1 each  shared single-port memory strobe and write enable.
REQ-016 mem_addr / mem_wdata  output  10 / 32  shared memory address and write data.
REQ-017 mem_rdata  input  32  shared memory read data.
REQ-018 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-019 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP.
REQ-020 In IDLE with at least one request, the arbiter SHALL latch the winner (port, address, we, wdata) and go to ISSUE; with no request it SHALL stay in IDLE.
REQ-021 Priority SHALL go to DM; IF SHALL win when dm_req=0, or when both requests are high and streak==STREAK.
REQ-022 streak SHALL increment (saturating at STREAK) on each DM grant taken while if_req=1, clear on each IF grant, and otherwise hold.
REQ-023 ISSUE SHALL last exactly one cycle, with mem_en=1, mem_we set to the latched we (always 0 for IF), and mem_addr/mem_wdata set from the latched values.
REQ-024 Outside ISSUE, mem_en and mem_we SHALL be 0, and mem_addr/mem_wdata SHALL hold their last values.
REQ-025 WAIT SHALL count MEM_LAT cycles and sample mem_rdata in the final one, then move to RESP.
REQ-026 Timing: request seen in IDLE at cycle 0, mem_en at cycle 1, valid at cycle MEM_LAT+2.
REQ-027 In RESP, exactly one of if_valid or dm_valid SHALL be high for one cycle, for the granted port only, and the FSM SHALL return to IDLE the next cycle.
REQ-028 For a read, the sampled data SHALL load into the granted port's rdata register in the RESP cycle.
REQ-029 For a DM write, dm_valid SHALL still pulse as an acknowledgement and dm_rdata SHALL hold its previous value.
REQ-030 A req still high in IDLE after its valid pulse SHALL be treated as a new request; back-to-back transactions therefore cost MEM_LAT+3 cycles.
REQ-031 Changes to a losing port's inputs while a transaction is in flight SHALL have no effect; the arbiter samples them only in IDLE.
REQ-032 A req that drops before its valid pulse SHALL NOT abort the transaction; valid still pulses.
REQ-033 The stall outputs if_stall = if_req & ~if_valid and dm_stall = dm_req & ~dm_valid SHALL be provided combinationally for the pipeline hazard logic.

Reset
REQ-034 While rst=1, the FSM SHALL be in IDLE, and streak, the latency counter, all mem_* outputs, if_rdata, dm_rdata, if_valid, dm_valid and busy SHALL be 0.
REQ-035 rst asserted mid-transaction SHALL abandon it with no valid pulse; the first request after release SHALL follow REQ-026 timing.

Structure
REQ-036 ADDR_W=10, DATA_W=32 and the FSM state encoding SHALL live in the shared package pipeline_pkg.
REQ-037 The block SHALL be a single module with no sub-modules; the latency counter and streak counter are inline.

Verification
REQ-038 IF-only read: MEM_LAT=1, if_addr=0x004, mem_rdata=0x20080005 -> mem_en at cycle 1, if_valid at cycle 3 with if_rdata=0x20080005, dm_valid=0 throughout.
REQ-039 Contention: if_req and dm_req rise together, dm_we=1, dm_addr=0x010, dm_wdata=0xDEADBEEF -> DM granted first with mem_we=1 and mem_wdata=0xDEADBEEF; IF completes MEM_LAT+3 cycles after DM.
REQ-040 Starvation guard: STREAK=4, dm_req and if_req held high continuously -> grant order DM,DM,DM,DM,IF,DM, with streak=0 after the IF grant.
REQ-041 Latency sweep: MEM_LAT=3, DM read of addr 0x3FF -> mem_en at cycle 1, valid at cycle 5, dm_rdata equal to mem_rdata driven in cycle 4.
REQ-042 Reset mid-WAIT: assert rst in cycle 2 of a DM read -> no dm_valid, all outputs 0, busy=0; an IF request after release completes at cycle 3.
REQ-043 Write ack: DM write followed by DM read of the same address -> dm_rdata unchanged at the write ack, then updated at the read ack.
